// File: rtl/decode_stage_if.sv
// Fetch-to-decode, decode-to-execute and writeback-to-regfile signals of the RV32I decode stage.
// The stage itself uses the slave modport; the surrounding pipeline (or a bench) uses master.
interface decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_funct3;
    logic        out_mod;
    logic        out_immediate;
    logic [31:0] out_val1;
    logic [31:0] out_val2;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, out_funct3, out_mod, out_immediate,
               out_val1, out_val2, out_rd, out_wen, out_pc, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, out_funct3, out_mod, out_immediate,
               out_val1, out_val2, out_rd, out_wen, out_pc, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode/operand-fetch stage with integrated register file and one-entry output register.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data into accepted and held bundles.
module decode_stage #(
    parameter int NREGS = 32
) (
    input logic          clk,
    input logic          rst,
    decode_stage_if.slave bus
);
    localparam int         AW        = $clog2(NREGS);
    localparam logic [5:0] NREGS_W   = 6'(NREGS);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [31:0] rf_reg [NREGS];
    logic [NREGS-1:0] wr_hit;

    logic        valid_reg, mod_reg, imm_reg, wen_reg, illegal_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] val1_reg, val2_reg, pc_reg;
    logic [4:0]  rd_reg;

    logic        in_ready, accept;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_val, rs2_val;
    logic        legal, dec_mod, dec_imm, dec_wen;
    logic [2:0]  dec_funct3;
    logic [31:0] dec_val1, dec_val2;

    function automatic logic idx_ok(input logic [4:0] idx);
        return {1'b0, idx} < NREGS_W;
    endfunction

    assign in_ready    = !rst && (!valid_reg || bus.out_ready);
    assign accept      = bus.in_valid && in_ready;
    assign bus.in_ready = in_ready;

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign f3     = bus.in_instr[14:12];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];
    assign f7     = bus.in_instr[31:25];

    // x0 has no write decode, so it stays at its reset value of zero.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr
        if (gi == 0) begin : g_zero
            assign wr_hit[gi] = 1'b0;
        end else begin : g_reg
            assign wr_hit[gi] = bus.wb_en && (bus.wb_rd == 5'(gi));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf_reg[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr_hit[i]) rf_reg[i] <= bus.wb_data;
            end
        end
    end

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0 && idx_ok(rs1)) rs1_val = rf_reg[rs1[AW-1:0]];
        if (rs2 != 5'd0 && idx_ok(rs2)) rs2_val = rf_reg[rs2[AW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
        if (bus.wb_en && rs1 != 5'd0 && bus.wb_rd == rs1) rs1_val = bus.wb_data;
        if (bus.wb_en && rs2 != 5'd0 && bus.wb_rd == rs2) rs2_val = bus.wb_data;
`endif
    end

    always_comb begin
        legal      = 1'b0;
        dec_funct3 = '0;
        dec_mod    = 1'b0;
        dec_imm    = 1'b0;
        dec_val1   = '0;
        dec_val2   = '0;
        case (opcode)
            OPC_OP: begin
                legal      = idx_ok(rd) && idx_ok(rs1) && idx_ok(rs2) &&
                             (f7 == 7'd0 || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
                dec_funct3 = f3;
                dec_mod    = bus.in_instr[30];
                dec_val1   = rs1_val;
                dec_val2   = rs2_val;
            end
            OPC_OPIMM: begin
                // Only the shift-immediates constrain funct7; other funct3 use it as immediate bits.
                legal      = idx_ok(rd) && idx_ok(rs1) &&
                             ((f3 == 3'b001) ? (f7 == 7'd0) :
                              (f3 == 3'b101) ? (f7 == 7'd0 || f7 == F7_ALT) : 1'b1);
                dec_funct3 = f3;
                dec_mod    = bus.in_instr[30];
                dec_imm    = 1'b1;
                dec_val1   = rs1_val;
                dec_val2   = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
            end
            OPC_LUI, OPC_AUIPC: begin
                legal    = idx_ok(rd);
                dec_imm  = 1'b1;
                dec_val1 = (opcode == OPC_AUIPC) ? bus.in_pc : 32'd0;
                dec_val2 = {bus.in_instr[31:12], 12'd0};
            end
            default: ;
        endcase
        if (!legal) begin
            dec_funct3 = '0;
            dec_mod    = 1'b0;
            dec_imm    = 1'b0;
            dec_val1   = '0;
            dec_val2   = '0;
        end
        dec_wen = legal && (rd != 5'd0);
    end

`ifdef DECODE_WB_BYPASS_EN
    logic [4:0] rs1_reg, rs2_reg;
    logic       src1_reg, src2_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            funct3_reg  <= '0;
            mod_reg     <= 1'b0;
            imm_reg     <= 1'b0;
            val1_reg    <= '0;
            val2_reg    <= '0;
            rd_reg      <= '0;
            wen_reg     <= 1'b0;
            pc_reg      <= '0;
            illegal_reg <= 1'b0;
`ifdef DECODE_WB_BYPASS_EN
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            src1_reg    <= 1'b0;
            src2_reg    <= 1'b0;
`endif
        end else if (accept) begin
            valid_reg   <= 1'b1;
            funct3_reg  <= dec_funct3;
            mod_reg     <= dec_mod;
            imm_reg     <= dec_imm;
            val1_reg    <= dec_val1;
            val2_reg    <= dec_val2;
            rd_reg      <= rd;
            wen_reg     <= dec_wen;
            pc_reg      <= bus.in_pc;
            illegal_reg <= !legal;
`ifdef DECODE_WB_BYPASS_EN
            rs1_reg     <= rs1;
            rs2_reg     <= rs2;
            src1_reg    <= legal && (opcode == OPC_OP || opcode == OPC_OPIMM);
            src2_reg    <= legal && (opcode == OPC_OP);
`endif
        end else begin
            if (valid_reg && bus.out_ready) valid_reg <= 1'b0;
`ifdef DECODE_WB_BYPASS_EN
            // A stalled bundle keeps tracking writeback so it never issues a stale operand.
            if (valid_reg && !bus.out_ready && bus.wb_en && bus.wb_rd != 5'd0) begin
                if (src1_reg && rs1_reg == bus.wb_rd) val1_reg <= bus.wb_data;
                if (src2_reg && rs2_reg == bus.wb_rd) val2_reg <= bus.wb_data;
            end
`endif
        end
    end

    assign bus.out_valid     = valid_reg;
    assign bus.out_funct3    = funct3_reg;
    assign bus.out_mod       = mod_reg;
    assign bus.out_immediate = imm_reg;
    assign bus.out_val1      = val1_reg;
    assign bus.out_val2      = val2_reg;
    assign bus.out_rd        = rd_reg;
    assign bus.out_wen       = wen_reg;
    assign bus.out_pc        = pc_reg;
    assign bus.out_illegal   = illegal_reg;
endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode and operand-fetch stage of the RV32I core, directly upstream of the ALU. It accepts one fetched instruction per cycle and reads the 32×32 integer register file. It registers a decoded bundle that drives the ALU inputs (`funct3`, `mod`, `immediate`, `val1`, `val2`) plus destination and PC metadata. The register file write port is fed back from writeback.

## Interface

Parameters:
- `NREGS`, default 32: number of architectural registers. Legal values are 32 (RV32I) or 16 (RV32E). Register indices ≥ NREGS are illegal.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_instr`  in  32  instruction word
- `in_pc`  in  32  address of `in_instr`
- `out_valid`  out  1  decoded bundle is valid
- `out_ready`  in  1  ALU/execute consumes the bundle
- `out_funct3`  out  3  ALU operation select
- `out_mod`  out  1  ALU modifier (instr[30] for OP/OP-IMM)
- `out_immediate`  out  1  val2 comes from an immediate
- `out_val1`, `out_val2`  out  32  ALU operands
- `out_rd`  out  5  destination register
- `out_wen`  out  1  result is written back
- `out_pc`  out  32  PC of the bundle
- `out_illegal`  out  1  instruction is not decodable
- `wb_en`  in  1  register file write enable
- `wb_rd`  in  5  write index
- `wb_data`  in  32  write data

## Operation

Handshake:
- `in_ready = !rst && (!out_valid || out_ready)`.
- An instruction is accepted when `in_valid && in_ready`. On accept, the output register loads the decoded bundle and `out_valid` becomes 1.
- The bundle retires when `out_valid && out_ready`. If no new instruction is accepted in that cycle, `out_valid` becomes 0.
- While `out_valid && !out_ready`, every `out_*` is held stable.

Decode, by opcode `in_instr[6:0]`:
- **OP (0110011):** `funct3 = instr[14:12]`, `mod = instr[30]`, `immediate = 0`, `val1 = x[rs1]`, `val2 = x[rs2]`, `wen = 1`. Legal only when funct7 is 0000000, or when funct7 is 0100000 with funct3 ∈ {000, 101}.
- **OP-IMM (0010011):** `funct3 = instr[14:12]`, `mod = instr[30]`, `immediate = 1`, `val1 = x[rs1]`, `val2 = sign-extended instr[31:20]`, `wen = 1`.
  - SLLI requires funct7 = 0.
  - SRLI/SRAI require funct7 ∈ {0000000, 0100000}.
- **LUI (0110111):** `funct3 = 000`, `mod = 0`, `immediate = 1`, `val1 = 0`, `val2 = {instr[31:12], 12'b0}`, `wen = 1`.
- **AUIPC (0010111):** as LUI, except `val1 = in_pc`.
- **Anything else, or an illegal encoding:** `illegal = 1`, `wen = 0`, `funct3 = 000`, `mod = 0`, `immediate = 0`, `val1 = val2 = 0`. `rd` and `pc` are still passed through.

Register file:
- x0 always reads 0. Writes with `wb_rd == 0` are ignored.
- Writes occur on the clock edge when `wb_en && !rst`.
- `rd`, `rs1` or `rs2` ≥ NREGS makes the instruction illegal.
- `out_wen = 0` whenever `rd == 0`.

## Timing

- Accept-to-`out_valid` latency is 1 cycle. Full throughput is 1 instruction/cycle when `out_ready` is held high.
- Reset values:
  - `out_valid = 0`; all other `out_*` = 0.
  - All registers x1..x(NREGS-1) = 0.
  - `in_ready = 0` while `rst` is high.
- Reset mid-operation: a held bundle is discarded; `in_ready` rises in the first cycle after `rst` falls.
- Simultaneous retire and accept: `out_valid` stays 1 and the new bundle replaces the old one on the same edge.
- Register read happens combinationally from `in_instr` in the accept cycle. Operands are frozen in the output register thereafter, except as described under Configuration.

## Configuration

- **`DECODE_WB_BYPASS_EN` defined:**
  - A same-cycle `wb_en` to a nonzero register matching rs1/rs2 of the accepted instruction supplies `wb_data` instead of the stale file value.
  - A held bundle (`out_valid && !out_ready`) whose register-sourced operand matches a nonzero `wb_rd` updates that operand to `wb_data` on the edge.
  - The stage stores rs1/rs2 indices and operand-source flags for this purpose.
- **Not defined:** the accepted instruction reads the pre-write value and held bundles never update. Upstream control must stall across read-after-write hazards.

## Test plan

- **Reset:** assert `rst` for 2 cycles with `in_valid = 1` → `in_ready = 0`, `out_valid = 0`, all outputs 0. Reading x5 after reset returns 0.
- **ADDI:** write x1 = 0x00000010, then issue `addi x2,x1,-1` (0xFFF08113) → one cycle later `out_valid = 1`, `funct3 = 000`, `immediate = 1`, `val1 = 0x10`, `val2 = 0xFFFFFFFF`, `rd = 2`, `wen = 1`.
- **SUB and SRAI:** `sub x3,x1,x2` gives `mod = 1`, `immediate = 0`. `srai x3,x1,4` gives `funct3 = 101`, `mod = 1`, `val2[4:0] = 4`.
- **LUI/AUIPC:** `lui x4,0x12345` gives `val1 = 0`, `val2 = 0x12345000`. AUIPC at pc 0x100 gives `val1 = 0x100`.
- **Stall:** hold `out_ready = 0` for 3 cycles → `in_ready = 0` and outputs stable. Raise `out_ready` while `in_valid = 1` → back-to-back bundles with no bubble.
- **Bypass:** `wb_en = 1`, `wb_rd = 1`, `wb_data = 0xDEADBEEF` in the same cycle as accepting `add x5,x1,x0` → `val1 = 0xDEADBEEF` with `DECODE_WB_BYPASS_EN`, old x1 without it. Also check that an opcode of 0x0000007F produces `illegal = 1`, `wen = 0`.
